// File: rtl/load_store_unit.sv
// load_store_unit: RV32 byte/half/word loads and stores onto a word-only RAM, with read-modify-write for SB/SH.
// Optional LSU_PERF_CNT_EN adds perf_loads/perf_stores/perf_errs response counters.
module load_store_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int RAM_AW     = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic                  rsp_err,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [RAM_AW-1:0]     ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic                  ram_read_en,
  output logic                  ram_write_en,
`ifdef LSU_PERF_CNT_EN
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic [31:0]           perf_loads,
  output logic [31:0]           perf_stores,
  output logic [31:0]           perf_errs
`else
  input  logic [DATA_WIDTH-1:0] ram_rdata
`endif
);
  typedef enum logic [2:0] {IDLE, RD, LD, WR, MRG} state_t;
  state_t state, state_nx;
  logic                  r_we;
  logic [2:0]            r_f3;
  logic [RAM_AW+1:0]     r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  accept, bad;
  logic [4:0]            sh;
  logic [DATA_WIDTH-1:0] lane, mask, ld_val;
  logic                  unused_addr_bits;
  assign unused_addr_bits = ^req_addr[ADDR_WIDTH-1:RAM_AW+2];
  assign req_ready = (state == IDLE) && !rst;
  assign ram_addr  = r_addr[RAM_AW+1:2];
  always_comb begin
    bad = (req_we && req_funct3[2]) || req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11 ||
          (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
          (req_funct3 == 3'b010 && req_addr[1:0] != 2'b00);
    accept = req_valid && req_ready;
    sh = {r_addr[1:0], 3'b000};
    lane = ram_rdata >> sh;
    ld_val = r_f3[1] ? lane :
             r_f3[0] ? {{16{~r_f3[2] & lane[15]}}, lane[15:0]} :
                       {{24{~r_f3[2] & lane[7]}}, lane[7:0]};
    mask = (r_f3[0] ? 32'h0000_FFFF : 32'h0000_00FF) << sh;
    state_nx = state == IDLE ? ((accept && !bad) ? ((req_we && req_funct3 == 3'b010) ? WR : RD) : IDLE) :
               state == RD   ? (r_we ? MRG : LD) : IDLE;
    ram_wdata = rst ? '0 :
                state == WR  ? r_wdata :
                state == MRG ? (ram_rdata & ~mask) | ((r_wdata << sh) & mask) : '0;
    ram_read_en  = state == RD && !rst;
    ram_write_en = (state == WR || state == MRG) && !rst;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      r_we      <= 1'b0;
      r_f3      <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state     <= state_nx;
      rsp_valid <= (accept && bad) || state == LD || state == WR || state == MRG;
      rsp_err   <= accept && bad;
      rsp_rdata <= state == LD ? ld_val : '0;
      if (accept) begin
        r_we    <= req_we;
        r_f3    <= req_funct3;
        r_addr  <= req_addr[RAM_AW+1:0];
        r_wdata <= req_wdata;
      end
    end
  end
`ifdef LSU_PERF_CNT_EN
  // Counters step on the same edge that raises rsp_valid for the matching class.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_loads  <= '0;
      perf_stores <= '0;
      perf_errs   <= '0;
    end else begin
      if (state == LD) perf_loads <= perf_loads + 32'd1;
      if (state == WR || state == MRG) perf_stores <= perf_stores + 32'd1;
      if (accept && bad) perf_errs <= perf_errs + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed and random requests against a word RAM model and an arithmetic reference memory.
module tb_load_store_unit;
  logic        clk = 1'b0, rst = 1'b1;
  logic        req_valid = 1'b0, req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, rsp_valid, rsp_err, ram_read_en, ram_write_en;
  logic [31:0] rsp_rdata, ram_wdata, ram_rdata;
  logic [9:0]  ram_addr;
  logic [31:0] mem [1024];
  logic [31:0] ref_mem [1024];
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_read_en(ram_read_en),
    .ram_write_en(ram_write_en), .ram_rdata(ram_rdata)
  );

  always @(posedge clk) begin
    if (ram_write_en) mem[ram_addr] <= ram_wdata;
    if (ram_read_en) ram_rdata <= mem[ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic is_illegal(input logic we, input logic [2:0] f3, input logic [31:0] a);
    int size = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
    if (f3 == 3 || f3 >= 6) return 1'b1;
    if (we && f3 >= 4) return 1'b1;
    return (a % size) != 0;
  endfunction

  function automatic logic [31:0] load_val(input logic [31:0] w, input logic [2:0] f3, input logic [31:0] a);
    int unsigned v = w >> (8 * (a % 4));
    case (f3)
      3'd0: return (v % 256) >= 128 ? (v % 256) - 256 : v % 256;
      3'd1: return (v % 65536) >= 32768 ? (v % 65536) - 65536 : v % 65536;
      3'd4: return v % 256;
      3'd5: return v % 65536;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] store_val(input logic [31:0] w, input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] d);
    int unsigned s = 8 * (a % 4);
    int unsigned span = (f3 == 0) ? 256 : 65536;
    int unsigned old_f = (w >> s) % span;
    if (f3 == 2) return d;
    return w - (old_f << s) + ((d % span) << s);
  endfunction

  task automatic do_req(input string tag, input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d);
    logic e = is_illegal(we, f3, a);
    int idx = (a / 4) % 1024;
    logic [31:0] exp_d = (we || e) ? 32'd0 : load_val(ref_mem[idx], f3, a);
    int exp_lat = e ? 1 : (we && f3 == 2) ? 2 : 3;
    int lat = 0, rd = 0, wr = 0, first_rd = 0, wait_n = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = d;
    while (!req_ready && wait_n < 20) begin
      @(negedge clk);
      wait_n++;
    end
    chk({tag, " ready"}, req_ready, 1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    do begin
      @(negedge clk);
      lat++;
      if (ram_read_en) begin
        rd++;
        if (first_rd == 0) first_rd = lat;
      end
      if (ram_write_en) wr++;
    end while (!rsp_valid && lat < 8);
    chk({tag, " lat"}, lat, exp_lat);
    chk({tag, " err"}, rsp_err, e);
    chk({tag, " rdata"}, rsp_rdata, exp_d);
    chk({tag, " reads"}, rd, (!e && !(we && f3 == 2)) ? 1 : 0);
    chk({tag, " writes"}, wr, (!e && we) ? 1 : 0);
    if (!e && !we) chk({tag, " rd_cycle"}, first_rd, 1);
    if (we && !e) ref_mem[idx] = store_val(ref_mem[idx], f3, a, d);
    chk({tag, " word"}, mem[idx], ref_mem[idx]);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[4] = 32'h8055_AA01;
    ref_mem[4] = 32'h8055_AA01;
    repeat (2) @(negedge clk);
    chk("rst rsp_valid", rsp_valid, 0);
    chk("rst rsp_err", rsp_err, 0);
    chk("rst rsp_rdata", rsp_rdata, 0);
    chk("rst ram_addr", ram_addr, 0);
    chk("rst ram_wdata", ram_wdata, 0);
    chk("rst strobes", {ram_read_en, ram_write_en}, 0);
    chk("rst ready", req_ready, 0);
    rst = 1'b0;
    #1 chk("ready after rst", req_ready, 1);

    do_req("lw10", 1'b0, 3'd2, 32'h10, 0);
    do_req("lb13", 1'b0, 3'd0, 32'h13, 0);
    do_req("lbu13", 1'b0, 3'd4, 32'h13, 0);
    do_req("lh12", 1'b0, 3'd1, 32'h12, 0);
    do_req("lhu12", 1'b0, 3'd5, 32'h12, 0);
    do_req("sb11", 1'b1, 3'd0, 32'h11, 32'h1234_56EE);
    chk("word4 after sb", mem[4], 32'h8055_EE01);
    do_req("sh12", 1'b1, 3'd1, 32'h12, 32'h0000_BEEF);
    chk("word4 after sh", mem[4], 32'hBEEF_EE01);
    do_req("lw12 err", 1'b0, 3'd2, 32'h12, 0);
    do_req("sh13 err", 1'b1, 3'd1, 32'h13, 32'hFFFF);
    do_req("f3 011 err", 1'b0, 3'd3, 32'h10, 0);
    do_req("sbu err", 1'b1, 3'd4, 32'h10, 32'h55);

    // SB aborted by reset while in the merge cycle
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd0; req_addr = 32'h11; req_wdata = 32'hA5;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort mrg write_en", ram_write_en, 1);
    rst = 1'b1;
    #1 chk("abort gated write_en", ram_write_en, 0);
    @(negedge clk);
    chk("abort rsp_valid", rsp_valid, 0);
    chk("abort ready in rst", req_ready, 0);
    rst = 1'b0;
    #1 chk("abort ready after", req_ready, 1);
    repeat (3) begin
      @(negedge clk);
      chk("abort no rsp", rsp_valid, 0);
    end
    chk("abort word4", mem[4], 32'hBEEF_EE01);

    // SW 0x14 then LW 0x14 with req_valid held
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'h14; req_wdata = 32'hCAFE_F00D;
    @(posedge clk);
    #1 req_we = 1'b0;
    ref_mem[5] = 32'hCAFE_F00D;
    @(negedge clk);
    chk("b2b ready busy", req_ready, 0);
    chk("b2b sw write_en", ram_write_en, 1);
    @(negedge clk);
    chk("b2b sw rsp", rsp_valid, 1);
    chk("b2b ready again", req_ready, 1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("b2b lw read_en", ram_read_en, 1);
    chk("b2b gap rsp", rsp_valid, 0);
    @(negedge clk);
    @(negedge clk);
    chk("b2b lw rsp", rsp_valid, 1);
    chk("b2b lw rdata", rsp_rdata, ref_mem[5]);

    for (int i = 0; i < 80; i++)
      do_req("rand", 1'(($urandom % 2)), 3'($urandom_range(0, 7)),
             ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 31)), $urandom);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
